// File: rtl/sha2_msg_sched_if.sv
// Stream interface for the SHA-256 message-schedule expander: input word stream,
// output schedule stream, abort and status. The block-count signal exists only when
// SHA2_SCHED_BLKCNT_EN is defined.
interface sha2_msg_sched_if;
  logic        abort_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_word_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_word_o;
  logic [5:0]  out_idx_o;
  logic        busy_o;
`ifdef SHA2_SCHED_BLKCNT_EN
  logic [15:0] blk_cnt_o;
`endif

  // Expander side
  modport slave (
    input  abort_i,
    input  in_valid_i,
    output in_ready_o,
    input  in_word_i,
    output out_valid_o,
    input  out_ready_i,
    output out_word_o,
    output out_idx_o,
    output busy_o
`ifdef SHA2_SCHED_BLKCNT_EN
    ,
    output blk_cnt_o
`endif
  );

  // Producer/consumer side
  modport master (
    output abort_i,
    output in_valid_i,
    input  in_ready_o,
    output in_word_i,
    input  out_valid_o,
    output out_ready_i,
    input  out_word_o,
    input  out_idx_o,
    input  busy_o
`ifdef SHA2_SCHED_BLKCNT_EN
    ,
    input  blk_cnt_o
`endif
  );
endinterface

// File: rtl/sha2_msg_sched.sv
// SHA-256 message-schedule expander. Takes W[0..15] of a block, emits W[0..63]
// one word per output handshake. W[16..63] are generated in place in a 16-entry
// circular buffer. Optional completed-block counter: SHA2_SCHED_BLKCNT_EN.
module sha2_msg_sched (
  input  logic             clk_i,
  input  logic             rst_i,
  sha2_msg_sched_if.slave  bus
);

  typedef enum logic [0:0] {StLoad, StExpand} state_e;

  state_e      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] wbuf_q [16];
  logic [31:0] wbuf_d [16];
  logic [31:0] out_word_q, out_word_d;
  logic [5:0]  out_idx_q, out_idx_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;

  logic        out_free;
  logic        out_hs;
  logic        in_ready;
  logic        accept;
  logic [31:0] w_new;
  logic [3:0]  idx_m2, idx_m7, idx_m15, idx_m16;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Handshake qualifiers; abort blocks any input acceptance in its cycle
  always_comb begin
    out_free = !out_valid_q || bus.out_ready_i;
    out_hs   = out_valid_q && bus.out_ready_i;
    in_ready = (state_q == StLoad) && out_free && !bus.abort_i;
    accept   = bus.in_valid_i && in_ready;
  end

  // Schedule recurrence; 4-bit index arithmetic wraps around the circular buffer
  always_comb begin
    idx_m2  = t_q[3:0] - 4'd2;
    idx_m7  = t_q[3:0] - 4'd7;
    idx_m15 = t_q[3:0] - 4'd15;
    idx_m16 = t_q[3:0];
    w_new   = ssig1(wbuf_q[idx_m2]) + wbuf_q[idx_m7] + ssig0(wbuf_q[idx_m15]) + wbuf_q[idx_m16];
  end

  // Next-state: load/expand FSM, buffer update, output register and busy flag
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    wbuf_d      = wbuf_q;
    out_word_d  = out_word_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    if (bus.abort_i) begin
      state_d     = StLoad;
      t_d         = 6'd0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      if (out_hs) begin
        out_valid_d = 1'b0;
        if (out_idx_q == 6'd63) busy_d = 1'b0;
      end
      unique case (state_q)
        StLoad: begin
          if (accept) begin
            wbuf_d[t_q[3:0]] = bus.in_word_i;
            out_word_d       = bus.in_word_i;
            out_idx_d        = t_q;
            out_valid_d      = 1'b1;
            t_d              = t_q + 6'd1;
            // A new block may start in the same cycle the previous W[63] leaves
            if (t_q == 6'd0) busy_d = 1'b1;
            if (t_q == 6'd15) state_d = StExpand;
          end
        end
        StExpand: begin
          if (out_free) begin
            // W[t-16] sits in this slot and is consumed by w_new before being replaced
            wbuf_d[t_q[3:0]] = w_new;
            out_word_d       = w_new;
            out_idx_d        = t_q;
            out_valid_d      = 1'b1;
            t_d              = t_q + 6'd1;
            if (t_q == 6'd63) state_d = StLoad;
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StLoad;
      t_q         <= 6'd0;
      for (int i = 0; i < 16; i++) wbuf_q[i] <= 32'd0;
      out_word_q  <= 32'd0;
      out_idx_q   <= 6'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      wbuf_q      <= wbuf_d;
      out_word_q  <= out_word_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SHA2_SCHED_BLKCNT_EN
  logic [15:0] blk_cnt_q, blk_cnt_d;

  // Counts W[63] handshakes; abort does not touch it
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (out_hs && out_idx_q == 6'd63) blk_cnt_d = blk_cnt_q + 16'd1;
  end

  // Block counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) blk_cnt_q <= 16'd0;
    else       blk_cnt_q <= blk_cnt_d;
  end

  assign bus.blk_cnt_o = blk_cnt_q;
`endif

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_word_o  = out_word_q;
  assign bus.out_idx_o   = out_idx_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: doc/sha2_msg_sched.md
# sha2_msg_sched

SHA-256 message-schedule expander feeding the round datapath that consumes the σ/Σ-function results. It accepts the 16 big-endian words of one padded 512-bit block over a valid/ready stream. It emits the full 64-word schedule W[0..63] on a second valid/ready stream, one word per handshake. W[16..63] are computed internally from a 16-entry circular buffer.

## Interface
- No parameters.
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- abort_i  in  1  synchronous abort of the current block.
- in_valid_i  in  1  in_word_i valid.
- in_ready_o  out  1  block accepts in_word_i this cycle.
- in_word_i  in  32  message word W[t], t = 0..15, in order.
- out_valid_o  out  1  out_word_o/out_idx_o valid.
- out_ready_i  in  1  consumer takes the output word this cycle.
- out_word_o  out  32  schedule word W[out_idx_o].
- out_idx_o  out  6  schedule index 0..63.
- busy_o  out  1  high from the first accepted word until the W[63] output handshake.
- blk_cnt_o  out  16  completed-block count; present only with SHA2_SCHED_BLKCNT_EN.

## Operation
- State: t (6-bit word counter), buf[0:15] (32-bit), FSM {LOAD, EXPAND}, output register (word, idx, valid).
- Output register is free when !out_valid_o || out_ready_i.
- In LOAD, in_ready_o = free. On in_valid_i && in_ready_o:
  - buf[t[3:0]] <= in_word_i.
  - Output register <= (in_word_i, t) with valid = 1.
  - t++.
  - After accepting t = 15, go to EXPAND.
- In EXPAND, in_ready_o = 0. Each cycle the output register is free:
  - W = σ1(buf[(t−2)&15]) + buf[(t−7)&15] + σ0(buf[(t−15)&15]) + buf[t&15], mod 2^32.
  - buf[t&15] <= W, which overwrites W[t−16] after it is read.
  - Output register <= (W, t), valid = 1.
  - t++.
- After issuing t = 63: t wraps to 0 and the FSM returns to LOAD. W[63] still drains through the output register. The next block's W[0] may be accepted in the same cycle W[63] is taken.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- busy_o:
  - Set on the first LOAD accept (t = 0).
  - Cleared on the output handshake with out_idx_o = 63, unless a new t = 0 accept occurs in the same cycle.
- abort_i (priority over all other events) in that cycle:
  - t = 0, FSM = LOAD, out_valid_o = 0, busy_o = 0.
  - Any input offered that cycle is not accepted: in_ready_o is forced to 0.
  - buf contents are don't-care.
- Output register holds word/idx stable while out_valid_o && !out_ready_i; words are never dropped or duplicated.

## Timing
- Reset values:
  - in_ready_o = 1 (LOAD, output free), out_valid_o = 0, out_word_o = 0, out_idx_o = 0, busy_o = 0, blk_cnt_o = 0.
  - t = 0, buf = 0.
- Latency: input accept to output valid is 1 cycle. EXPAND words are issued 1 cycle after the register frees.
- Throughput:
  - 1 word/cycle with out_ready_i and in_valid_i held high.
  - A block takes 64 cycles, back-to-back with no bubble between blocks.
- W[t−2] is written at least 2 cycles before it is read, so no forwarding path is required.
- The combinational path is σ0/σ1 plus a 4-operand 32-bit add; no multicycle paths.
- Backpressure stalls in LOAD deassert in_ready_o. Backpressure in EXPAND freezes t and buf.

## Configuration
- SHA2_SCHED_BLKCNT_EN defined:
  - blk_cnt_o exists and increments by 1 on each output handshake with out_idx_o = 63.
  - Wraps 0xFFFF→0; reset to 0 by rst_i; unaffected by abort_i.
- SHA2_SCHED_BLKCNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- "abc" block, out_ready_i = 1:
  - Input W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018.
  - Outputs idx 0..63 on consecutive cycles.
  - W16 = 0x61626380, W17 = 0x000F0000.
  - W63 matches the software reference model; busy_o falls after idx 63.
- Random backpressure (out_ready_i 50%) on random blocks:
  - Output stream is identical to the model.
  - Word/idx stay stable while stalled.
  - in_ready_o = 0 throughout EXPAND.
- Two blocks back-to-back, in_valid_i held high:
  - Second block's W0 is accepted in the same cycle as the W63 handshake.
  - 128 outputs in 128 cycles; busy_o stays high.
- abort_i asserted at idx 30 while out_valid_o = 1 and stalled:
  - Next cycle out_valid_o = 0, busy_o = 0, in_ready_o = 1.
  - The next block restarts at idx 0 and is correct.
- rst_i pulsed asynchronously mid-EXPAND:
  - All outputs take their reset values immediately.
  - The following "abc" block is correct.
- With SHA2_SCHED_BLKCNT_EN: after 3 complete blocks plus 1 aborted block, blk_cnt_o = 3.
